// File: rtl/addb_pipe.sv
// Two-stage ADPCM reconstructed-signal adder (SR = DQ + SE) with channel tag,
// valid/ready flow control and overflow counting; ADDB_PIPE_SAT_EN clamps SR.
module addb_pipe #(
    parameter int DQ_W  = 16,
    parameter int SE_W  = 15,
    parameter int SR_W  = 16,
    parameter int CH_W  = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [DQ_W-1:0]  dq,
    input  logic [SE_W-1:0]  se,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [SR_W-1:0]  sr,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             cnt_clr
);

    localparam int SUM_W = ((DQ_W > SE_W) ? DQ_W : SE_W) + 1;
    localparam int EXT_W = ((SUM_W > SR_W) ? SUM_W : SR_W) + 1;

    logic                    s1_valid_q;
    logic [CH_W-1:0]         s1_ch_q;
    logic signed [SUM_W-1:0] s1_dqi_q;
    logic signed [SUM_W-1:0] s1_sei_q;

    logic                    s2_valid_q;
    logic [CH_W-1:0]         s2_ch_q;
    logic [SR_W-1:0]         s2_sr_q;
    logic                    s2_ovf_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    s2_load;
    logic                    in_fire;
    logic signed [SUM_W-1:0] mag_x;
    logic signed [SUM_W-1:0] dqi_d;
    logic signed [SUM_W-1:0] sei_d;
    logic signed [SUM_W-1:0] sum;
    logic signed [EXT_W-1:0] sum_x;
    logic [SR_W-1:0]         lo;
    logic                    ovf_d;
    logic [SR_W-1:0]         sr_d;

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;

    // Sign-magnitude to two's complement; negative zero naturally maps to 0.
    assign mag_x = {{(SUM_W-DQ_W+1){1'b0}}, dq[DQ_W-2:0]};
    assign dqi_d = dq[DQ_W-1] ? -mag_x : mag_x;
    assign sei_d = {{(SUM_W-SE_W){se[SE_W-1]}}, se};

    assign sum   = s1_dqi_q + s1_sei_q;
    assign sum_x = {{(EXT_W-SUM_W){sum[SUM_W-1]}}, sum};
    assign lo    = sum_x[SR_W-1:0];
    assign ovf_d = sum_x != {{(EXT_W-SR_W){lo[SR_W-1]}}, lo};

`ifdef ADDB_PIPE_SAT_EN
    assign sr_d = !ovf_d          ? lo :
                  sum_x[EXT_W-1]  ? {1'b1, {(SR_W-1){1'b0}}} :
                                    {1'b0, {(SR_W-1){1'b1}}};
`else
    assign sr_d = lo;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_dqi_q   <= '0;
            s1_sei_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_fire) begin
                s1_ch_q  <= in_ch;
                s1_dqi_q <= dqi_d;
                s1_sei_q <= sei_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_ch_q    <= '0;
            s2_sr_q    <= '0;
            s2_ovf_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_ch_q  <= s1_ch_q;
                s2_sr_q  <= sr_d;
                s2_ovf_q <= ovf_d;
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (s2_load && s1_valid_q && ovf_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_ch    = s2_ch_q;
    assign sr        = s2_sr_q;
    assign out_ovf   = s2_ovf_q;
    assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_addb_pipe.sv
// Bench for addb_pipe: directed cases, backpressure, counter saturation,
// reset and a randomized stream against an integer reference model.
module tb_addb_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_ch;
    logic [15:0] dq;
    logic [14:0] se;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_ch;
    logic [15:0] sr;
    logic        out_ovf;
    logic [7:0]  ovf_cnt;
    logic        cnt_clr;

    logic        c4_in_ready;
    logic        c4_out_valid;
    logic [4:0]  c4_out_ch;
    logic [15:0] c4_sr;
    logic        c4_out_ovf;
    logic [3:0]  c4_cnt;

    int checks = 0;
    int failures = 0;
    int nov = 0;
    int pops = 0;
    bit acc;
    logic [21:0] q[$];

    always #5 clk = ~clk;

    addb_pipe u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .dq(dq), .se(se),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .sr(sr), .out_ovf(out_ovf), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
    );

    addb_pipe #(.CNT_W(4)) u_c4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(c4_in_ready), .in_ch(in_ch),
        .dq(dq), .se(se),
        .out_valid(c4_out_valid), .out_ready(out_ready), .out_ch(c4_out_ch),
        .sr(c4_sr), .out_ovf(c4_out_ovf), .ovf_cnt(c4_cnt), .cnt_clr(cnt_clr)
    );

    // Reference: {ch, ovf, sr} from plain integer arithmetic.
    function automatic logic [21:0] model(logic [15:0] d, logic [14:0] s,
                                          logic [4:0] c);
        int dqi;
        int sei;
        int sum;
        int r;
        bit ov;
        logic [31:0] rv;
        dqi = d[15] ? -int'(d[14:0]) : int'(d[14:0]);
        sei = int'($signed(s));
        sum = dqi + sei;
        ov  = (sum > 32767) || (sum < -32768);
        r   = sum;
`ifdef ADDB_PIPE_SAT_EN
        if (sum > 32767) r = 32767;
        else if (sum < -32768) r = -32768;
`endif
        rv = r;
        return {c, ov, rv[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [21:0] e;
        @(negedge clk);
        acc = 1'b0;
        if (out_valid) begin
            chk("q_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                chk("out", {out_ch, out_ovf, sr}, q[0]);
                if (out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
        if (in_valid && in_ready) begin
            e = model(dq, se, in_ch);
            q.push_back(e);
            if (e[16]) nov++;
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [15:0] d, input logic [14:0] s,
                       input logic [4:0] c, input logic [15:0] esr,
                       input logic eovf);
        dq = d; se = s; in_ch = c; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("lat1_valid", out_valid, 0);
        cyc();
        chk("lat2_valid", out_valid, 1);
        chk("lat2_sr", sr, esr);
        chk("lat2_ovf", out_ovf, eovf);
        chk("lat2_ch", out_ch, c);
        cyc();
        chk("cnt", ovf_cnt, nov);
    endtask

    initial begin
        int sent;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        dq = '0; se = '0; in_ch = '0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sr", sr, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_cnt", ovf_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        one(16'h8005, 15'h0010, 5'd3, 16'h000B, 1'b0);
        one(16'h8000, 15'h7FFF, 5'd7, 16'hFFFF, 1'b0);
`ifdef ADDB_PIPE_SAT_EN
        one(16'h7FFF, 15'h3FFF, 5'd9, 16'h7FFF, 1'b1);
        one(16'hFFFF, 15'h4000, 5'd30, 16'h8000, 1'b1);
`else
        one(16'h7FFF, 15'h3FFF, 5'd9, 16'hBFFE, 1'b1);
        one(16'hFFFF, 15'h4000, 5'd30, 16'h4001, 1'b1);
`endif
        chk("cnt_two", ovf_cnt, 2);

        // Backpressure: only two samples fit while the output is blocked.
        out_ready = 1'b0;
        sent = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = sent < 4;
            dq = 16'h0100 + 16'(sent); se = 15'h0001; in_ch = 5'(sent + 1);
            cyc();
            if (acc) sent++;
        end
        chk("bp_accepted", sent, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = sent < 4;
            dq = 16'h0100 + 16'(sent); se = 15'h0001; in_ch = 5'(sent + 1);
            cyc();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("bp_pops", pops, 4);
        chk("bp_drained", q.size(), 0);

        // Randomized stream with random backpressure; upstream holds data.
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                dq = 16'($urandom);
                se = 15'($urandom);
                in_ch = 5'($urandom);
            end
            out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();
        chk("rnd_drained", q.size(), 0);
        chk("rnd_cnt", ovf_cnt, (nov > 255) ? 255 : nov);
        chk("rnd_cnt4", c4_cnt, (nov > 15) ? 15 : nov);

        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        nov = 0;
        chk("clr_cnt", ovf_cnt, 0);
        chk("clr_cnt4", c4_cnt, 0);

        // 20 overflows: 4-bit counter saturates at 15.
        sent = 0;
        dq = 16'h7FFF; se = 15'h3FFF; in_ch = 5'd1;
        for (int i = 0; i < 40 && sent < 20; i++) begin
            in_valid = 1'b1;
            cyc();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("sat_sent", sent, 20);
        repeat (3) cyc();
        chk("sat_cnt8", ovf_cnt, 20);
        chk("sat_cnt4", c4_cnt, 15);
        repeat (3) cyc();
        chk("sat_hold4", c4_cnt, 15);

        // Clear coincides with an overflow load into the output stage.
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        nov = 0;
        chk("clrwin_ovf", out_ovf, 1);
        chk("clrwin_valid", out_valid, 1);
        chk("clrwin_cnt", ovf_cnt, 0);
        chk("clrwin_cnt4", c4_cnt, 0);
        cyc();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1; dq = 16'h7FFF; se = 15'h3FFF; in_ch = 5'd2;
        cyc();
        dq = 16'hFFFF; se = 15'h4000; in_ch = 5'd4;
        cyc();
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_cnt", ovf_cnt, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_cnt", ovf_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete();
        nov = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        one(16'h8005, 15'h0010, 5'd3, 16'h000B, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
